// File: rtl/xbutton_events_pkg.sv
// -----------------------------------------------------------------------------
// xbutton_events_pkg
// Shared definitions for the button event peripheral: bus data width, register
// addresses, status/control bit positions and the button-to-event-code mapping.
// -----------------------------------------------------------------------------
package xbutton_events_pkg;

    // picoVersat data bus width
    localparam int unsigned DATA_W = 32;

    // Register map
    typedef enum logic [1:0] {
        RegStat  = 2'd0,
        RegPop   = 2'd1,
        RegLevel = 2'd2,
        RegRsvd  = 2'd3
    } reg_addr_e;

    // Status register layout (read of RegStat)
    localparam int unsigned StatEmptyBit = 0;
    localparam int unsigned StatCountLsb = 1;
    localparam int unsigned StatCountW   = 3;
    localparam int unsigned StatOvfBit   = 4;

    // Control bits (write of RegStat)
    localparam int unsigned CtlClrOvfBit = 4;
    localparam int unsigned CtlFlushBit  = 5;

    // Code 0 means "no event", so button i is reported as i+1.
    function automatic int unsigned event_code(input int unsigned idx);
        return idx + 1;
    endfunction

    // Counter/pointer width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned val);
        return (val > 1) ? $clog2(val) : 1;
    endfunction

endpackage

// File: rtl/xbutton_events_debounce.sv
// -----------------------------------------------------------------------------
// xdebounce
// Single-button synchronizer + debouncer. The raw level goes through two flops;
// the debounced level only flips after DEB_CYCLES consecutive synchronized
// samples that disagree with it.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   din_i    raw asynchronous button level (1 = pressed)
//   level_o  debounced level (registered)
//   rise_o   one-cycle pulse in the cycle before level_o goes 0->1
// -----------------------------------------------------------------------------
module xdebounce
    import xbutton_events_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned     CntW    = clog2_min1(DEB_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Any agreeing sample restarts the run; the toggle also clears the counter.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = ~level_q & level_d;

endmodule

// File: rtl/xbutton_events.sv
// -----------------------------------------------------------------------------
// xbutton_events
// Push-button peripheral for picoVersat: debounces N_BUTT buttons, turns each
// debounced press into an event code (button index + 1) queued in a small FIFO,
// and exposes status / pop / level registers on the data bus.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   butt_in   raw button levels, 1 = pressed
//   sel       peripheral select
//   we        write enable (qualified by sel)
//   addr      register address (RegStat / RegPop / RegLevel)
//   data_in   write data (RegStat: bit4 clears overflow, bit5 flushes)
//   data_out  registered read data, updated on reads only
//   butt      debounced button levels
// -----------------------------------------------------------------------------
module xbutton_events
    import xbutton_events_pkg::*;
#(
    parameter int unsigned N_BUTT     = 3,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BUTT-1:0] butt_in,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [N_BUTT-1:0] butt
);

    localparam int unsigned CodeW = clog2_min1(N_BUTT + 1);
    localparam int unsigned PtrW  = clog2_min1(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    // ---------------------------------------------------------------- debounce
    logic [N_BUTT-1:0] rise;

    for (genvar g = 0; g < N_BUTT; g++) begin : g_deb
        xdebounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .din_i  (butt_in[g]),
            .level_o(butt[g]),
            .rise_o (rise[g])
        );
    end

    // ---------------------------------------------------------------- state
    logic [N_BUTT-1:0] pending_q, pending_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] data_out_q;
    logic [CodeW-1:0]  mem_q [FIFO_DEPTH];

    // ---------------------------------------------------------------- bus decode
    logic rd_en, wr_en, ctl_wr, flush, clr_ovf;
    logic empty, full, pop;

    assign rd_en   = sel & ~we;
    assign wr_en   = sel & we;
    assign ctl_wr  = wr_en && (addr == RegStat);
    assign flush   = ctl_wr && data_in[CtlFlushBit];
    assign clr_ovf = ctl_wr && data_in[CtlClrOvfBit];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign pop     = rd_en && (addr == RegPop) && !empty;

    // Only bits 4 and 5 of a control write carry meaning.
    logic unused_data_in;
    assign unused_data_in = ^{data_in[DATA_W-1:CtlFlushBit+1], data_in[CtlClrOvfBit-1:0]};

    // ---------------------------------------------------------------- push select
    logic              push_req;
    logic [CodeW-1:0]  push_code;
    logic [N_BUTT-1:0] pend_sel;

    // Scan downwards so the lowest pending index is the one left standing.
    always_comb begin
        push_req  = 1'b0;
        push_code = '0;
        pend_sel  = '0;
        for (int i = N_BUTT - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                push_req    = 1'b1;
                push_code   = CodeW'(event_code($unsigned(i)));
                pend_sel    = '0;
                pend_sel[i] = 1'b1;
            end
        end
    end

    // A pop in the same cycle frees the slot the push needs; a flush kills the push.
    logic push_ok, ovf_set;
    assign push_ok = push_req && !flush && (!full || pop);
    assign ovf_set = push_req && !flush && full && !pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    // ---------------------------------------------------------------- next state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pending_d  = (pending_q & ~pend_sel) | rise;
        overflow_d = overflow_q;

        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pending_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- read mux
    logic [DATA_W-1:0] rdata;

    always_comb begin
        rdata = '0;
        case (addr)
            RegStat: begin
                rdata[StatEmptyBit]                  = empty;
                rdata[StatCountLsb +: StatCountW]    = StatCountW'(count_q);
                rdata[StatOvfBit]                    = overflow_q;
            end
            RegPop: begin
                if (!empty) rdata = DATA_W'(mem_q[rd_ptr_q]);
            end
            RegLevel: rdata = DATA_W'(butt);
            default:  rdata = '0;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (rd_en) data_out_q <= rdata;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_code;
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_xbutton_events.sv
module tb_xbutton_events;
    import xbutton_events_pkg::*;

    localparam int unsigned NB    = 3;
    localparam int unsigned DEB   = 16;
    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     butt_in;
    logic              sel, we;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data_in, data_out;
    logic [NB-1:0]     butt;

    always #5 clk = ~clk;

    xbutton_events #(
        .N_BUTT    (NB),
        .DEB_CYCLES(DEB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .butt_in (butt_in),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .butt    (butt)
    );

    int vectors;
    int miscompares;

    // Reference model: synchronizer delay line, run lengths of disagreeing
    // samples, a queue of event codes and the sticky overflow flag.
    logic [NB-1:0]     m_s1, m_s2, m_lvl, m_pend;
    int                m_run [NB];
    int                m_q [$];
    bit                m_ovf;
    logic [DATA_W-1:0] m_dout;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_ovf = 0; m_dout = '0;
        m_q.delete();
        for (int i = 0; i < NB; i++) m_run[i] = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit rd, pop, flush, clr, full;
        int code, st;
        logic [NB-1:0] rise;
        rd    = sel && !we;
        pop   = rd && addr == 2'd1 && m_q.size() > 0;
        flush = sel && we && addr == 2'd0 && data_in[5];
        clr   = sel && we && addr == 2'd0 && data_in[4];
        full  = m_q.size() == DEPTH;
        if (rd) begin
            case (addr)
                2'd0: begin
                    st = (m_q.size() == 0 ? 1 : 0) + 2 * m_q.size() + (m_ovf ? 16 : 0);
                    m_dout = DATA_W'(st);
                end
                2'd1: m_dout = (m_q.size() > 0) ? DATA_W'(m_q[0]) : '0;
                2'd2: m_dout = DATA_W'(m_lvl);
                default: m_dout = '0;
            endcase
        end
        code = 0;
        for (int i = NB - 1; i >= 0; i--) if (m_pend[i]) code = i + 1;
        if (pop) m_q.delete(0);
        if (code != 0) begin
            m_pend[code-1] = 1'b0;
            if (!flush) begin
                if (!full || pop) m_q.push_back(code);
                else m_ovf = 1;
            end
        end
        if (!(code != 0 && !flush && full && !pop) && clr) m_ovf = 0;
        if (flush) m_q.delete();
        rise = '0;
        for (int i = 0; i < NB; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    if (m_lvl[i]) rise[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_pend = flush ? '0 : (m_pend | rise);
        m_s2 = m_s1;
        m_s1 = butt_in;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sel = 0; we = 0; addr = 0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [DATA_W-1:0] d);
        sel = 1; we = 0; addr = a;
        tick();
        d = data_out;
        sel = 0; addr = 0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [DATA_W-1:0] v);
        sel = 1; we = 1; addr = a; data_in = v;
        tick();
        sel = 0; we = 0; addr = 0; data_in = '0;
    endtask

    task automatic press(input int i);
        butt_in[i] = 1'b1;
        idle(DEB + 4);
        butt_in[i] = 1'b0;
        idle(DEB + 4);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        logic [DATA_W-1:0] d;
        butt_in = '0;
        do_reset();
        vectors++;
        if (butt !== '0) begin
            miscompares++; $display("FAIL reset_butt: got %0h expected 0", butt);
        end
        vectors++;
        if (data_out !== '0) begin
            miscompares++; $display("FAIL reset_dout: got %0h expected 0", data_out);
        end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL reset_stat: got %0h expected 1", d); end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL empty_pop: got %0h expected 0", d); end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL addr3: got %0h expected 0", d); end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++; $display("FAIL empty_pop_stat: got %0h expected 1", d);
        end
    endtask

    task automatic test_glitch();
        logic [DATA_W-1:0] d;
        int first;
        do_reset();
        repeat (2) begin
            butt_in[1] = 1'b1; idle(3);
            butt_in[1] = 1'b0; idle(3);
        end
        vectors++;
        if (butt !== '0) begin miscompares++; $display("FAIL glitch_level: got %0h expected 0", butt); end
        butt_in[1] = 1'b1;
        first = 0;
        for (int k = 1; k <= DEB + 6; k++) begin
            tick();
            if (butt[1] && first == 0) first = k;
            vectors++;
            if (butt !== m_lvl) begin
                miscompares++; $display("FAIL glitch_butt: got %0h expected %0h", butt, m_lvl);
            end
        end
        vectors++;
        if (first != DEB + 2) begin
            miscompares++; $display("FAIL glitch_latency: got %0d expected %0d", first, DEB + 2);
        end
        bus_read(2'd2, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL level_reg: got %0h expected 2", d); end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL glitch_stat: got %0h expected 2", d); end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL glitch_pop: got %0h expected 2", d); end
        butt_in[1] = 1'b0;
        idle(DEB + 4);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h1 || butt !== '0) begin
            miscompares++; $display("FAIL release_stat: got %0h/%0h expected 1/0", d, butt);
        end
    endtask

    task automatic test_simultaneous();
        logic [DATA_W-1:0] d;
        do_reset();
        butt_in = 3'b101;
        idle(DEB + 2);
        tick();
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL simul_cnt1: got %0h expected 2", d); end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h4) begin miscompares++; $display("FAIL simul_cnt2: got %0h expected 4", d); end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL simul_pop1: got %0h expected 1", d); end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL simul_pop3: got %0h expected 3", d); end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL simul_pop0: got %0h expected 0", d); end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL simul_empty: got %0h expected 1", d); end
        butt_in = '0;
        idle(DEB + 4);
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] d;
        int exp_codes [4] = '{1, 2, 3, 1};
        do_reset();
        press(0); press(1); press(2); press(0); press(1);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h18) begin miscompares++; $display("FAIL ovf_stat: got %0h expected 18", d); end
        for (int k = 0; k < 4; k++) begin
            bus_read(2'd1, d);
            vectors++;
            if (d !== DATA_W'(exp_codes[k])) begin
                miscompares++; $display("FAIL ovf_pop%0d: got %0h expected %0h", k, d, exp_codes[k]);
            end
        end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h11) begin miscompares++; $display("FAIL ovf_drained: got %0h expected 11", d); end
        bus_write(2'd0, 32'h10);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL ovf_clear: got %0h expected 1", d); end
    endtask

    task automatic test_full_pop();
        logic [DATA_W-1:0] d;
        int exp_codes [4] = '{2, 1, 3, 1};
        do_reset();
        press(2); press(1); press(0); press(2);
        butt_in[0] = 1'b1;
        idle(DEB + 2);
        bus_read(2'd1, d);  // lands on the edge that pushes code 1
        vectors++;
        if (d !== 32'h3) begin miscompares++; $display("FAIL fullpop_head: got %0h expected 3", d); end
        idle(2);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h8) begin miscompares++; $display("FAIL fullpop_stat: got %0h expected 8", d); end
        for (int k = 0; k < 4; k++) begin
            bus_read(2'd1, d);
            vectors++;
            if (d !== DATA_W'(exp_codes[k])) begin
                miscompares++; $display("FAIL fullpop%0d: got %0h expected %0h", k, d, exp_codes[k]);
            end
        end
        butt_in[0] = 1'b0;
        idle(DEB + 4);
    endtask

    task automatic test_reset_midflight();
        logic [DATA_W-1:0] d;
        do_reset();
        press(0); press(1);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h4) begin miscompares++; $display("FAIL mid_prestat: got %0h expected 4", d); end
        butt_in[2] = 1'b1;
        idle(DEB / 2);
        rst = 1'b1;
        #1;
        vectors++;
        if (data_out !== '0 || butt !== '0) begin
            miscompares++; $display("FAIL async_rst: got %0h/%0h expected 0/0", data_out, butt);
        end
        butt_in[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL mid_stat: got %0h expected 1", d); end
        idle(DEB + 6);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h1 || butt !== '0) begin
            miscompares++; $display("FAIL mid_noevent: got %0h/%0h expected 1/0", d, butt);
        end
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] d;
        do_reset();
        press(0); press(1); press(2);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h6) begin miscompares++; $display("FAIL flush_pre: got %0h expected 6", d); end
        bus_write(2'd0, 32'h20);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL flush_stat: got %0h expected 1", d); end
        press(1);
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL flush_next: got %0h expected 2", d); end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL flush_code: got %0h expected 2", d); end
    endtask

    task automatic test_held_reset();
        logic [DATA_W-1:0] d;
        int first;
        butt_in = 3'b001;
        do_reset();
        first = 0;
        for (int k = 1; k <= DEB + 6; k++) begin
            tick();
            if (butt[0] && first == 0) first = k;
        end
        vectors++;
        if (first != DEB + 2) begin
            miscompares++; $display("FAIL held_latency: got %0d expected %0d", first, DEB + 2);
        end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL held_stat: got %0h expected 2", d); end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL held_code: got %0h expected 1", d); end
        butt_in = '0;
        idle(DEB + 4);
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 19) == 0) butt_in[i] = ~butt_in[i];
            end
            sel = 0; we = 0; addr = 0; data_in = '0;
            r = $urandom_range(0, 99);
            if (r < 25) begin
                sel = 1; addr = 2'($urandom_range(0, 3));
            end else if (r < 29) begin
                sel = 1; we = 1; addr = 2'($urandom_range(0, 3));
                data_in = DATA_W'($urandom);
                if ($urandom_range(0, 3) != 0) data_in[5] = 1'b0;
            end
            tick();
            vectors++;
            if (butt !== m_lvl) begin
                miscompares++; $display("FAIL rand_butt@%0d: got %0h expected %0h", c, butt, m_lvl);
            end
            vectors++;
            if (data_out !== m_dout) begin
                miscompares++;
                $display("FAIL rand_dout@%0d: got %0h expected %0h", c, data_out, m_dout);
            end
        end
        sel = 0; we = 0; addr = 0; data_in = '0; butt_in = '0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        butt_in = '0;
        sel = 0; we = 0; addr = 0; data_in = '0;
        model_reset();
        test_reset();
        test_glitch();
        test_simultaneous();
        test_overflow();
        test_full_pop();
        test_reset_midflight();
        test_flush();
        test_held_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
